// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding, Q1.14 twiddle table for N=32 and bit-reverse helper.
// Smaller transforms index the table with k << (5 - LOG2N).
package fft_pkg;

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    localparam int TW_BITS = 16;

    // W_k = exp(-j*2*pi*k/32) in Q1.14: real = cos, imag = -sin
    localparam logic signed [15:0] TW_RE [16] = '{
        16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
        16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
        16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
       -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069
    };
    localparam logic signed [15:0] TW_IM [16] = '{
        16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
       -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
       -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623,
       -16'sd11585, -16'sd9102,  -16'sd6270,  -16'sd3196
    };

    // Reverses the low `bits` bits of v; higher result bits are zero
    function automatic logic [4:0] bitrev(input logic [4:0] v, input int bits);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) r[i] = v[bits-1-i];
        return r;
    endfunction

endpackage

// File: rtl/fft_cbfly.sv
// fft_cbfly: combinational radix-2 complex butterfly with 1/2 scaling.
// Ports: a_*, b_* data inputs (WIDTH, signed); w_* twiddle (TWW, Q1.TW_FRAC);
//        p_* = (A + B*W) >>> 1, q_* = (A - B*W) >>> 1.
module fft_cbfly #(
    parameter int WIDTH   = 16,
    parameter int TWW     = 16,
    parameter int TW_FRAC = 14
) (
    input  logic [WIDTH-1:0] a_re,
    input  logic [WIDTH-1:0] a_im,
    input  logic [WIDTH-1:0] b_re,
    input  logic [WIDTH-1:0] b_im,
    input  logic [TWW-1:0]   w_re,
    input  logic [TWW-1:0]   w_im,
    output logic [WIDTH-1:0] p_re,
    output logic [WIDTH-1:0] p_im,
    output logic [WIDTH-1:0] q_re,
    output logic [WIDTH-1:0] q_im
);
    localparam int MW = WIDTH + TWW;
    localparam int W1 = WIDTH + 1;

    logic signed [MW-1:0]    bre, bim, wre, wim, mre, mim;
    logic signed [WIDTH-1:0] bwr, bwi;
    logic signed [W1-1:0]    spr, spi, sqr, sqi;

    always_comb begin
        bre = MW'($signed(b_re));
        bim = MW'($signed(b_im));
        wre = MW'($signed(w_re));
        wim = MW'($signed(w_im));
        mre = bre * wre - bim * wim;
        mim = bre * wim + bim * wre;
        // arithmetic shift truncates toward -inf
        bwr = WIDTH'(mre >>> TW_FRAC);
        bwi = WIDTH'(mim >>> TW_FRAC);
        spr = W1'($signed(a_re)) + W1'(bwr);
        spi = W1'($signed(a_im)) + W1'(bwi);
        sqr = W1'($signed(a_re)) - W1'(bwr);
        sqi = W1'($signed(a_im)) - W1'(bwi);
        p_re = WIDTH'(spr >>> 1);
        p_im = WIDTH'(spi >>> 1);
        q_re = WIDTH'(sqr >>> 1);
        q_im = WIDTH'(sqi >>> 1);
    end

endmodule

// File: rtl/fft_engine_n.sv
// fft_engine_n: N-point (N = 2^LOG2N) radix-2 DIT complex FFT, in-place, one butterfly per cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_re/in_im sample input stream;
//        out_valid/out_ready/out_re/out_im/out_last natural-order result stream; busy during compute.
// Option: FFT_INVERSE_EN adds input inv (sampled on a frame's first sample) selecting conjugate twiddles.
module fft_engine_n
    import fft_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LOG2N   = 3,
    parameter int TW_FRAC = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_last,
`ifdef FFT_INVERSE_EN
    input  logic             inv,
`endif
    output logic             busy
);
    localparam int N  = 1 << LOG2N;
    localparam int AW = LOG2N;
    localparam int BW = LOG2N - 1;

    state_t state, nxt;

    logic [WIDTH-1:0] mem_re [N];
    logic [WIDTH-1:0] mem_im [N];

    logic [AW-1:0] load_cnt, out_cnt, ld_addr, bf_ext, mask_lo, top, bot;
    logic [BW-1:0] bf_cnt;
    logic [2:0]    stage;
    logic [3:0]    tw_idx;
    logic          in_fire, out_fire, last_stage, last_bf, inv_q;
    logic [TW_BITS-1:0] w_re, w_im;
    logic [WIDTH-1:0]   p_re, p_im, q_re, q_im;

    // Butterfly addressing: top inserts a 0 bit at position `stage` into the butterfly index
    always_comb begin
        ld_addr    = AW'(bitrev(5'(load_cnt), LOG2N));
        bf_ext     = {1'b0, bf_cnt};
        mask_lo    = (AW'(1) << stage) - AW'(1);
        top        = ((bf_ext & ~mask_lo) << 1) | (bf_ext & mask_lo);
        bot        = top | (AW'(1) << stage);
        // k = pos << (LOG2N-1-s), then scaled by 2^(5-LOG2N) into the 32-point table
        tw_idx     = 4'(5'(bf_ext & mask_lo) << (3'd4 - stage));
        w_re       = TW_RE[tw_idx];
        w_im       = inv_q ? -TW_IM[tw_idx] : TW_IM[tw_idx];
        last_stage = stage == 3'(LOG2N - 1);
        last_bf    = (&bf_cnt) && last_stage;
    end

    fft_cbfly #(.WIDTH(WIDTH), .TWW(TW_BITS), .TW_FRAC(TW_FRAC)) u_bfly (
        .a_re(mem_re[top]), .a_im(mem_im[top]),
        .b_re(mem_re[bot]), .b_im(mem_im[bot]),
        .w_re(w_re), .w_im(w_im),
        .p_re(p_re), .p_im(p_im), .q_re(q_re), .q_im(q_im)
    );

    always_comb begin
        in_ready  = state == S_LOAD;
        busy      = state == S_COMPUTE;
        out_valid = state == S_UNLOAD;
        out_last  = out_valid && (&out_cnt);
        out_re    = out_valid ? mem_re[out_cnt] : '0;
        out_im    = out_valid ? mem_im[out_cnt] : '0;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        nxt       = (in_fire && (&load_cnt)) ? S_COMPUTE :
                    (busy && last_bf)        ? S_UNLOAD  :
                    (out_fire && out_last)   ? S_LOAD    : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOAD;
            load_cnt <= '0;
            bf_cnt   <= '0;
            stage    <= '0;
            out_cnt  <= '0;
        end else begin
            state <= nxt;
            if (in_fire) load_cnt <= load_cnt + AW'(1);
            if (busy) begin
                bf_cnt <= bf_cnt + BW'(1);
                if (&bf_cnt) stage <= last_stage ? 3'd0 : stage + 3'd1;
            end
            if (out_fire) out_cnt <= out_cnt + AW'(1);
        end
    end

    // Sample memory is deliberately not reset
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_re[ld_addr] <= in_re;
            mem_im[ld_addr] <= in_im;
        end else if (busy) begin
            mem_re[top] <= p_re;
            mem_im[top] <= p_im;
            mem_re[bot] <= q_re;
            mem_im[bot] <= q_im;
        end
    end

`ifdef FFT_INVERSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv_q <= 1'b0;
        else if (in_fire && load_cnt == '0) inv_q <= inv;
    end
`else
    assign inv_q = 1'b0;
`endif

endmodule
